// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch and
// the MEM-stage load/store unit. Data accesses win unless a fetch has been
// passed over STARVE_LIM times in a row. Each access waits at most MAX_WAIT
// cycles for m_ack before it is aborted with an error pulse.
module mem_port_arbiter #(
  parameter int MAX_WAIT   = 15,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  input  logic        m_ack,
  input  logic [63:0] m_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        dm_valid,
  output logic [63:0] dm_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  // The abort fires on the ackless BUSY cycle that brings the count to MAX_WAIT.
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} state_t;

  state_t        state;
  state_t        nextState;
  logic [WW-1:0] waitCnt;
  logic [SW-1:0] starveCnt;
  logic          dmPending;
  logic          ifPending;
  logic          busy;
  logic          grantDm;
  logic          grantIf;
  logic          ackTake;
  logic          timeOut;

  // Arbitration decision, completion strobes and the combinational stalls.
  always_comb begin
    dmPending = dm_read | dm_write;
    ifPending = if_req;
    busy      = (state == IF_BUSY) || (state == DM_BUSY);
    grantDm   = (state == IDLE) && dmPending && (!ifPending || (starveCnt < STARVE_MAX));
    grantIf   = (state == IDLE) && ifPending && !grantDm;
    ackTake   = busy && m_ack;
    timeOut   = busy && !m_ack && (waitCnt == WAIT_LAST);
    stall_if  = if_req & ~if_valid;
    stall_mem = dmPending & ~dm_valid;
  end

  // Next-state selection; DONE always falls back to IDLE without granting.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (grantDm) nextState = DM_BUSY;
        else if (grantIf) nextState = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: begin
        if (ackTake || timeOut) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end

  // Registered memory-side request, completion pulses, read data and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_valid  <= 1'b0;
      dm_rdata  <= '0;
      err       <= 1'b0;
      waitCnt   <= '0;
      starveCnt <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err      <= 1'b0;
      if (grantDm) begin
        // A simultaneous read+write is carried out as a write and flagged.
        m_req   <= 1'b1;
        m_we    <= dm_write;
        m_addr  <= dm_addr;
        m_wdata <= dm_wdata;
        waitCnt <= '0;
        err     <= dm_read & dm_write;
        if (ifPending && (starveCnt < STARVE_MAX)) starveCnt <= starveCnt + 1'b1;
      end else if (grantIf) begin
        m_req     <= 1'b1;
        m_we      <= 1'b0;
        m_addr    <= if_addr;
        m_wdata   <= '0;
        waitCnt   <= '0;
        starveCnt <= '0;
      end else if (busy) begin
        if (ackTake || timeOut) begin
          // An ack on the last allowed cycle still counts as a normal completion.
          m_req <= 1'b0;
          err   <= timeOut;
          if (state == IF_BUSY) begin
            if_valid <= 1'b1;
            if_rdata <= ackTake ? m_rdata[31:0] : 32'd0;
          end else begin
            dm_valid <= 1'b1;
            dm_rdata <= ackTake ? m_rdata : 64'd0;
          end
        end else begin
          waitCnt <= waitCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: two requesters and a
// memory responder with random ack latency (including no ack at all).
module tb_mem_port_arbiter;

  localparam int MAX_WAIT   = 15;
  localparam int STARVE_LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        dm_read;
  logic        dm_write;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        m_ack;
  logic [63:0] m_rdata;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_valid;
  logic [63:0] dm_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic        both;
  } req_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          vcyc;
  } done_t;

  req_t  ifQ[$];
  req_t  dmQ[$];
  done_t doneQ[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit monOn = 1'b0;
  bit respOn = 1'b0;
  bit ifActive = 1'b0;
  bit dmActive = 1'b0;

  // Memory responder outputs, overridable by the directed reset test.
  logic        respAck = 1'b0;
  logic [63:0] respData = '0;
  logic        dirAck = 1'b0;
  logic [63:0] dirData = '0;
  assign m_ack   = respOn ? respAck : dirAck;
  assign m_rdata = respOn ? respData : dirData;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: chooses when (or whether) to ack each access and records the
  // completion the arbiter owes for it.
  logic prevMreqR = 1'b0;
  int   j = 0;
  int   ackAt = 0;
  always @(negedge clk) begin
    if (respOn) begin
      if (m_req) begin
        if (!prevMreqR) begin
          j = 0;
          case ($urandom_range(0, 9))
            0, 1:    ackAt = MAX_WAIT;      // ack on the last allowed cycle
            2:       ackAt = 0;             // never ack -> timeout
            3:       ackAt = 1;
            default: ackAt = $urandom_range(1, 6);
          endcase
        end
        j++;
        respData = {$urandom, $urandom};
        if (ackAt == j) begin
          respAck = 1'b1;
          doneQ.push_back('{respData, 1'b0, cyc + 1});
        end else begin
          respAck = 1'b0;
          if (j == MAX_WAIT) doneQ.push_back('{64'd0, 1'b1, cyc + 1});
        end
      end else begin
        // Stray acks while no access is outstanding must be ignored.
        respAck  = ($urandom_range(0, 7) == 0);
        respData = {$urandom, $urandom};
      end
      prevMreqR = m_req;
    end
  end

  // Monitor: pops expectations whenever the DUT starts an access or completes one.
  logic        prevMreq = 1'b0;
  logic        prevIf = 1'b0;
  logic        prevDm = 1'b0;
  logic        curOwnerDm = 1'b0;
  logic [63:0] curAddr = '0;
  logic [31:0] lastIf = '0;
  logic [63:0] lastDm = '0;
  int          starve = 0;
  always @(negedge clk) begin
    logic  expErr;
    logic  ownerDm;
    req_t  r;
    done_t d;
    if (monOn) begin
      expErr = 1'b0;
      if (m_req && !prevMreq) begin
        if (!prevIf && !prevDm) begin
          chk("spurious_grant", 64'd1, 64'd0);
        end else begin
          ownerDm = prevDm && (!prevIf || starve < STARVE_LIM);
          curOwnerDm = ownerDm;
          if (ownerDm) begin
            if (dmQ.size() == 0) chk("dm_queue_empty", 64'd0, 64'd1);
            else begin
              r = dmQ.pop_front();
              chk("grant_dm_we", {63'd0, m_we}, {63'd0, r.we});
              chk("grant_dm_addr", m_addr, r.addr);
              if (r.we) chk("grant_dm_wdata", m_wdata, r.wdata);
              expErr = r.both;
              curAddr = r.addr;
            end
            if (prevIf && starve < STARVE_LIM) starve++;
          end else begin
            if (ifQ.size() == 0) chk("if_queue_empty", 64'd0, 64'd1);
            else begin
              r = ifQ.pop_front();
              chk("grant_if_we", {63'd0, m_we}, 64'd0);
              chk("grant_if_addr", m_addr, r.addr);
              chk("grant_if_wdata", m_wdata, 64'd0);
              curAddr = r.addr;
            end
            starve = 0;
          end
        end
      end else if (m_req && prevMreq) begin
        chk("addr_hold", m_addr, curAddr);
      end

      if (if_valid || dm_valid) begin
        chk("one_valid", {63'd0, if_valid & dm_valid}, 64'd0);
        if (doneQ.size() == 0) chk("done_queue_empty", 64'd0, 64'd1);
        else begin
          d = doneQ.pop_front();
          chk("valid_cycle", 64'(cyc), 64'(d.vcyc));
          chk("valid_owner", {63'd0, dm_valid}, {63'd0, curOwnerDm});
          chk("mreq_dropped", {63'd0, m_req}, 64'd0);
          if (dm_valid) begin
            chk("dm_rdata", dm_rdata, d.rdata);
            lastDm = d.rdata;
          end else begin
            chk("if_rdata", {32'd0, if_rdata}, {32'd0, d.rdata[31:0]});
            lastIf = d.rdata[31:0];
          end
          expErr = expErr | d.err;
        end
      end else begin
        chk("if_rdata_hold", {32'd0, if_rdata}, {32'd0, lastIf});
        chk("dm_rdata_hold", dm_rdata, lastDm);
      end

      chk("err", {63'd0, err}, {63'd0, expErr});
      chk("stall_if", {63'd0, stall_if}, {63'd0, if_req & ~if_valid});
      chk("stall_mem", {63'd0, stall_mem}, {63'd0, (dm_read | dm_write) & ~dm_valid});
      prevMreq = m_req;
      prevIf   = if_req;
      prevDm   = dm_read | dm_write;
    end
  end

  // One stimulus step: retire requests on their valid pulse, maybe raise new ones.
  task automatic step(input bit allowNew);
    int kind;
    @(posedge clk);
    #1;
    if (ifActive) begin
      if (if_valid) begin
        if_req = 1'b0;
        ifActive = 1'b0;
      end
    end else if (allowNew && $urandom_range(0, 3) == 0) begin
      if_addr = {$urandom, $urandom};
      if_req = 1'b1;
      ifActive = 1'b1;
      ifQ.push_back('{if_addr, 1'b0, 64'd0, 1'b0});
    end
    if (dmActive) begin
      if (dm_valid) begin
        dm_read = 1'b0;
        dm_write = 1'b0;
        dmActive = 1'b0;
      end
    end else if (allowNew && $urandom_range(0, 9) < 7) begin
      kind = $urandom_range(0, 9);
      dm_addr = {$urandom, $urandom};
      dm_wdata = {$urandom, $urandom};
      dm_read = (kind == 0) || (kind > 4);
      dm_write = (kind <= 4);
      dmActive = 1'b1;
      dmQ.push_back('{dm_addr, dm_write, dm_wdata, dm_read & dm_write});
    end
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    dm_read = 1'b0;
    dm_write = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_req", {63'd0, m_req}, 64'd0);
    chk("rst_m_we", {63'd0, m_we}, 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_m_wdata", m_wdata, 64'd0);
    chk("rst_valids", {62'd0, if_valid, dm_valid}, 64'd0);
    chk("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
    chk("rst_dm_rdata", dm_rdata, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    respOn = 1'b1;
    monOn = 1'b1;
    for (int c = 0; c < 3000; c++) step(1'b1);

    // Drain outstanding requests within a bounded number of cycles.
    waited = 0;
    while ((ifActive || dmActive) && waited < 1000) begin
      step(1'b0);
      waited++;
    end
    chk("drain_timeout", {62'd0, ifActive, dmActive}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("left_done", 64'(doneQ.size()), 64'd0);
    chk("left_ifq", 64'(ifQ.size()), 64'd0);
    chk("left_dmq", 64'(dmQ.size()), 64'd0);
    monOn = 1'b0;
    respOn = 1'b0;

    // Reset in the middle of a fetch: the request drops, no valid, late ack ignored.
    dirAck = 1'b0;
    if_addr = 64'h40;
    if_req = 1'b1;
    waited = 0;
    while (!m_req && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("rst_test_grant", {63'd0, m_req}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_m_req", {63'd0, m_req}, 64'd0);
    chk("midrst_if_valid", {63'd0, if_valid}, 64'd0);
    reset = 1'b0;
    if_req = 1'b0;
    dirAck = 1'b1;
    dirData = 64'h1234_5678_9abc_def0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("late_ack_valid", {62'd0, if_valid, dm_valid}, 64'd0);
      chk("late_ack_m_req", {63'd0, m_req}, 64'd0);
      chk("late_ack_if_rdata", {32'd0, if_rdata}, 64'd0);
      chk("late_ack_err", {63'd0, err}, 64'd0);
    end
    dirAck = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
